// File: rtl/cdb_arbiter.sv
// cdb_arbiter: rotating-priority complete-stage scheduler placing up to CDB_W finished FU results on the CDB.
// Optional feature macro: CDB_BRANCH_FIRST_EN gives the branch FU (BR_IDX) a fixed claim on slot 0.
package cdb_arbiter_pkg;
    localparam int XLEN  = 32;
    localparam int PR_W  = 6;
    localparam int ROB_W = 5;

    typedef struct packed {
        logic             valid;
        logic             halt;
        logic             if_take_branch;
        logic [XLEN-1:0]  target_pc;
        logic [PR_W-1:0]  dest_pr;
        logic [XLEN-1:0]  dest_value;
        logic [ROB_W-1:0] rob_entry;
    } FU_COMPLETE_PACKET;

    typedef struct packed {
        logic [PR_W-1:0] t0;
        logic [PR_W-1:0] t1;
        logic [PR_W-1:0] t2;
    } CDB_T_PACKET;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int NUM_FU = 8,
    parameter int CDB_W  = 3,
    parameter int BR_IDX = 7
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              squash,
    input  logic [NUM_FU-1:0]                 fu_finish,
    input  FU_COMPLETE_PACKET [NUM_FU-1:0]    fu_packet_in,
    output logic [NUM_FU-1:0]                 fu_grant,
    output FU_COMPLETE_PACKET [CDB_W-1:0]     cdb_packet_out,
    output CDB_T_PACKET                       cdb_t,
    output logic [$clog2(NUM_FU)-1:0]         rr_ptr_display
);

    localparam int PTR_W = $clog2(NUM_FU);
    localparam int CNT_W = $clog2(CDB_W + 1);
    localparam logic [PTR_W:0]   NUM_FU_C = (PTR_W + 1)'(NUM_FU);
    localparam logic [CNT_W-1:0] CDB_W_C  = CNT_W'(CDB_W);
    localparam logic [PTR_W-1:0] BR_C     = PTR_W'(BR_IDX);
    localparam logic [PTR_W-1:0] LAST_C   = PTR_W'(NUM_FU - 1);

    logic                          arb_en;
    logic                          br_claim;
    logic [NUM_FU-1:0]             rr_req;
    logic [PTR_W:0]                scan_sum;
    logic [PTR_W-1:0]              scan_idx;
    logic [CNT_W-1:0]              n_win;
    logic                          rr_any;
    logic [PTR_W-1:0]              rr_last;
    logic [PTR_W-1:0]              slot_idx [CDB_W];
    logic [CDB_W-1:0]              slot_vld;

    FU_COMPLETE_PACKET [CDB_W-1:0] cdb_d, cdb_q;
    CDB_T_PACKET                   cdb_t_d, cdb_t_q;
    logic [PTR_W-1:0]              rr_ptr_d, rr_ptr_q;

    // Grants are suppressed during a flush and while reset is held low.
    assign arb_en = reset & ~squash;

`ifdef CDB_BRANCH_FIRST_EN
    assign br_claim = arb_en & fu_finish[BR_IDX];
`else
    assign br_claim = 1'b0;
`endif

    // A claimed branch is removed from the rotating scan so it cannot win twice.
    assign rr_req = br_claim ? (fu_finish & ~(NUM_FU'(1) << BR_IDX)) : fu_finish;

    always_comb begin
        fu_grant = '0;
        slot_vld = '0;
        for (int s = 0; s < CDB_W; s++) begin
            slot_idx[s] = '0;
        end
        n_win    = '0;
        rr_any   = 1'b0;
        rr_last  = '0;
        scan_sum = '0;
        scan_idx = '0;

        if (br_claim) begin
            fu_grant[BR_C] = 1'b1;
            slot_idx[0]    = BR_C;
            slot_vld[0]    = 1'b1;
            n_win          = CNT_W'(1);
        end

        // Walk upward from the pointer, wrapping past NUM_FU-1 within the same cycle.
        for (int k = 0; k < NUM_FU; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
            if (scan_sum >= NUM_FU_C) begin
                scan_sum = scan_sum - NUM_FU_C;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (arb_en && rr_req[scan_idx] && (n_win < CDB_W_C)) begin
                fu_grant[scan_idx] = 1'b1;
                slot_idx[n_win]    = scan_idx;
                slot_vld[n_win]    = 1'b1;
                n_win              = n_win + CNT_W'(1);
                rr_any             = 1'b1;
                rr_last            = scan_idx;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < CDB_W; s++) begin
            cdb_d[s] = '0;
            if (slot_vld[s]) begin
                cdb_d[s]       = fu_packet_in[slot_idx[s]];
                cdb_d[s].valid = 1'b1;
            end
        end

        // The tag bus is three slots wide; PR 0 doubles as "no tag".
        cdb_t_d    = '0;
        cdb_t_d.t0 = cdb_d[0].valid ? cdb_d[0].dest_pr : '0;
        cdb_t_d.t1 = cdb_d[1].valid ? cdb_d[1].dest_pr : '0;
        cdb_t_d.t2 = cdb_d[2].valid ? cdb_d[2].dest_pr : '0;

        rr_ptr_d = rr_ptr_q;
        if (squash) begin
            rr_ptr_d = '0;
        end else if (rr_any) begin
            rr_ptr_d = (rr_last == LAST_C) ? '0 : rr_last + PTR_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_q    <= '0;
            cdb_t_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            cdb_q    <= cdb_d;
            cdb_t_q  <= cdb_t_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign cdb_packet_out = cdb_q;
    assign cdb_t          = cdb_t_q;
    assign rr_ptr_display = rr_ptr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed steps plus randomized FU traffic against a queue-based model.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

`ifdef CDB_BRANCH_FIRST_EN
    localparam int MAX_WAIT = 3;
`else
    localparam int MAX_WAIT = 2;
`endif

    logic                         clock = 1'b0;
    logic                         reset = 1'b0;
    logic                         squash = 1'b0;
    logic [7:0]                   fu_finish = '0;
    FU_COMPLETE_PACKET [7:0]      fu_packet_in;
    logic [7:0]                   fu_grant;
    FU_COMPLETE_PACKET [2:0]      cdb_packet_out;
    CDB_T_PACKET                  cdb_t;
    logic [2:0]                   rr_ptr_display;

    int                vectors = 0;
    int                miscompares = 0;
    int                m_ptr = 0;
    int                exp_ptr_next = 0;
    logic [7:0]        exp_grant;
    logic [7:0]        last_grant;
    FU_COMPLETE_PACKET exp_next [3];
    FU_COMPLETE_PACKET m_out [3];
    int                waitc [8];

    cdb_arbiter dut (
        .clock          (clock),
        .reset          (reset),
        .squash         (squash),
        .fu_finish      (fu_finish),
        .fu_packet_in   (fu_packet_in),
        .fu_grant       (fu_grant),
        .cdb_packet_out (cdb_packet_out),
        .cdb_t          (cdb_t),
        .rr_ptr_display (rr_ptr_display)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic FU_COMPLETE_PACKET rand_pkt();
        FU_COMPLETE_PACKET p;
        p.valid          = 1'($urandom_range(0, 1));
        p.halt           = 1'($urandom_range(0, 1));
        p.if_take_branch = 1'($urandom_range(0, 1));
        p.target_pc      = $urandom();
        p.dest_pr        = 6'($urandom_range(0, 63));
        p.dest_value     = $urandom();
        p.rob_entry      = 5'($urandom_range(0, 31));
        return p;
    endfunction

    function automatic logic [5:0] tag_of(input FU_COMPLETE_PACKET p);
        return p.valid ? p.dest_pr : 6'd0;
    endfunction

    // Winners are the first three requesters met when reading FUs in rotated priority order.
    function automatic void model_comb();
        int wins[$];
        int last_rr = -1;
        exp_grant    = '0;
        exp_ptr_next = m_ptr;
        for (int s = 0; s < 3; s++) exp_next[s] = '0;
        if (squash) begin
            exp_ptr_next = 0;
            return;
        end
`ifdef CDB_BRANCH_FIRST_EN
        if (fu_finish[7]) wins.push_back(7);
`endif
        for (int k = 0; k < 8; k++) begin
            int f = (m_ptr + k) % 8;
`ifdef CDB_BRANCH_FIRST_EN
            if (f == 7) continue;
`endif
            if (fu_finish[f] && wins.size() < 3) begin
                wins.push_back(f);
                last_rr = f;
            end
        end
        foreach (wins[i]) begin
            exp_grant[wins[i]] = 1'b1;
            exp_next[i]        = fu_packet_in[wins[i]];
            exp_next[i].valid  = 1'b1;
        end
        if (last_rr >= 0) exp_ptr_next = (last_rr + 1) % 8;
    endfunction

    task automatic check_outputs(input string tag);
        for (int s = 0; s < 3; s++)
            chk($sformatf("%s.slot%0d", tag, s), 128'(cdb_packet_out[s]), 128'(m_out[s]));
        chk({tag, ".t0"}, 128'(cdb_t.t0), 128'(tag_of(m_out[0])));
        chk({tag, ".t1"}, 128'(cdb_t.t1), 128'(tag_of(m_out[1])));
        chk({tag, ".t2"}, 128'(cdb_t.t2), 128'(tag_of(m_out[2])));
        chk({tag, ".ptr"}, 128'(rr_ptr_display), 128'(m_ptr));
    endtask

    task automatic model_reset();
        m_ptr = 0;
        for (int s = 0; s < 3; s++) m_out[s] = '0;
    endtask

    // Inputs are driven at posedge+1; grants sampled at +2, registered outputs at the next posedge+1.
    task automatic step(input string tag);
        model_comb();
        #1;
        last_grant = fu_grant;
        chk({tag, ".grant"}, 128'(fu_grant), 128'(exp_grant));
        @(posedge clock);
        m_ptr = exp_ptr_next;
        for (int s = 0; s < 3; s++) m_out[s] = exp_next[s];
        #1;
        check_outputs(tag);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            fu_packet_in[i] = rand_pkt();
            waitc[i] = 0;
        end
        model_reset();

        // Reset held with every FU requesting
        fu_finish = 8'hFF;
        repeat (2) @(posedge clock);
        #1;
        chk("rst.grant", 128'(fu_grant), 128'(8'h00));
        check_outputs("rst");
        fu_finish = '0;
        reset     = 1'b1;
        @(posedge clock);
        #1;

        // Basic: three requesters from pointer 0
        for (int i = 0; i < 3; i++) fu_packet_in[i] = rand_pkt();
        fu_finish = 8'h07;
        step("basic");
        chk("basic.grant_c", 128'(last_grant), 128'(8'h07));
        chk("basic.ptr_c", 128'(rr_ptr_display), 128'(3'd3));
        chk("basic.slot0_pr", 128'(cdb_packet_out[0].dest_pr), 128'(fu_packet_in[0].dest_pr));

        // Squash beats requests, then the same request is served from pointer 0
        fu_finish = 8'h0F;
        squash    = 1'b1;
        step("squash");
        chk("squash.grant_c", 128'(last_grant), 128'(8'h00));
        chk("squash.ptr_c", 128'(rr_ptr_display), 128'(3'd0));
        squash = 1'b0;
        step("post_squash");
        chk("post_squash.grant_c", 128'(last_grant), 128'(8'h07));
        fu_finish = '0;
        squash    = 1'b1;
        step("sq_idle");
        squash = 1'b0;

        // Fairness and wrap with every FU held requesting
        for (int i = 0; i < 8; i++) fu_packet_in[i] = rand_pkt();
        fu_finish = 8'hFF;
        step("fair1");
`ifndef CDB_BRANCH_FIRST_EN
        chk("fair1.grant_c", 128'(last_grant), 128'(8'h07));
        chk("fair1.ptr_c", 128'(rr_ptr_display), 128'(3'd3));
`endif
        step("fair2");
`ifndef CDB_BRANCH_FIRST_EN
        chk("fair2.grant_c", 128'(last_grant), 128'(8'h38));
        chk("fair2.ptr_c", 128'(rr_ptr_display), 128'(3'd6));
`endif
        step("fair3");
`ifndef CDB_BRANCH_FIRST_EN
        chk("fair3.grant_c", 128'(last_grant), 128'(8'hC1));
        chk("fair3.ptr_c", 128'(rr_ptr_display), 128'(3'd1));
`endif

        // Single tag from FU5
        fu_packet_in[5]         = rand_pkt();
        fu_packet_in[5].dest_pr = 6'd17;
        fu_finish               = 8'h20;
        step("single");
        chk("single.grant_c", 128'(last_grant), 128'(8'h20));
        chk("single.t0_c", 128'(cdb_t.t0), 128'(6'd17));
        chk("single.t1_c", 128'(cdb_t.t1), 128'(6'd0));
        chk("single.slot1_v", 128'(cdb_packet_out[1].valid), 128'(1'b0));
        chk("single.slot2_v", 128'(cdb_packet_out[2].valid), 128'(1'b0));

        // No requests: pointer holds, all slots invalid
        fu_finish = '0;
        step("idle");

        // Valid result with no destination register still occupies a slot
        fu_packet_in[1]         = rand_pkt();
        fu_packet_in[1].dest_pr = 6'd0;
        fu_finish               = 8'h02;
        step("nodest");
        chk("nodest.valid_c", 128'(cdb_packet_out[0].valid), 128'(1'b1));
        chk("nodest.t0_c", 128'(cdb_t.t0), 128'(6'd0));

`ifdef CDB_BRANCH_FIRST_EN
        fu_finish = '0;
        squash    = 1'b1;
        step("br_sq");
        squash = 1'b0;
        for (int i = 0; i < 8; i++) fu_packet_in[i] = rand_pkt();
        fu_finish = 8'h8F;
        step("brfirst");
        chk("brfirst.grant_c", 128'(last_grant), 128'(8'h83));
        chk("brfirst.slot0_c", 128'(cdb_packet_out[0].dest_value), 128'(fu_packet_in[7].dest_value));
        chk("brfirst.slot1_c", 128'(cdb_packet_out[1].dest_value), 128'(fu_packet_in[0].dest_value));
        chk("brfirst.slot2_c", 128'(cdb_packet_out[2].dest_value), 128'(fu_packet_in[1].dest_value));
        chk("brfirst.ptr_c", 128'(rr_ptr_display), 128'(3'd2));
`endif

        // Randomized traffic obeying the FU hold-until-grant handshake
        fu_finish = '0;
        for (int i = 0; i < 8; i++) waitc[i] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < 8; i++) begin
                if (!fu_finish[i] && $urandom_range(0, 1) == 1) begin
                    fu_finish[i]    = 1'b1;
                    fu_packet_in[i] = rand_pkt();
                end
            end
            squash = ($urandom_range(0, 15) == 0);
            step("rand");
            for (int i = 0; i < 8; i++) begin
                if (last_grant[i]) begin
                    fu_finish[i] = 1'b0;
                    waitc[i]     = 0;
                end else if (fu_finish[i]) begin
                    if (squash) begin
                        fu_finish[i] = 1'b0;
                        waitc[i]     = 0;
                    end else begin
                        waitc[i]++;
                        chk($sformatf("starve.fu%0d", i), 128'(waitc[i] <= MAX_WAIT), 128'(1'b1));
                    end
                end
            end
            squash = 1'b0;
        end

        // Asynchronous reset mid-run with all FUs requesting
        fu_finish = 8'hFF;
        step("pre_rst");
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst.grant", 128'(fu_grant), 128'(8'h00));
        check_outputs("midrst");
        @(posedge clock);
        #1;
        reset = 1'b1;
        step("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Complete-stage scheduler sitting between the eight functional units (ALU_1..3, LS_1..2, MULT_1..2, BRANCH) and the 3-wide CDB. Each cycle it selects up to three finished FU results with rotating (round-robin) priority. It returns per-FU grants that the FUs use as their ready/ack. It registers the winners onto the CDB packet and tag bus consumed by the RS wakeup, the map table ready bits and the ROB completion logic.

## Interface
Parameters:
- NUM_FU, 8: number of requesting FUs; index order ALU_1=0 … BRANCH=7.
- CDB_W, 3: CDB slots per cycle.
- BR_IDX, 7: index of the branch FU, used only under the configuration macro.

Ports:
- clock  input  1  single design clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- squash  input  1  precise-state flush from ROB retire; active high.
- fu_finish  input  NUM_FU  per-FU result-pending request.
- fu_packet_in  input  NUM_FU x FU_COMPLETE_PACKET  per-FU result: valid, halt, if_take_branch, target_pc, dest_pr, dest_value, rob_entry.
- fu_grant  output  NUM_FU  combinational per-FU ack, same cycle as the request.
- cdb_packet_out  output  CDB_W x FU_COMPLETE_PACKET  registered CDB results.
- cdb_t  output  CDB_T_PACKET  registered tags t0/t1/t2, one per slot.
- rr_ptr_display  output  $clog2(NUM_FU)  current priority pointer; debug only.

## Operation
- Priority scan starts at rr_ptr and walks upward modulo NUM_FU. The first CDB_W requesters (fu_finish[i]=1) are granted.
- The 1st winner goes to slot 0, the 2nd to slot 1, the 3rd to slot 2.
- fu_grant[i]=1 only for winners. It is 0 for every FU while squash=1 or reset is asserted.
- FU handshake: an FU holds fu_finish and fu_packet_in stable until it sees fu_grant=1 in the same cycle. It may present a new result on the following cycle.
- Pointer update when ≥1 grant: rr_ptr <= (index of last winner + 1) mod NUM_FU. With zero grants the pointer is unchanged.
- Slot registers: a winning slot loads its FU's packet with valid=1. Unused slots load valid=0 and all other fields 0.
- cdb_t.tk: set to the slot's dest_pr when that slot is valid, otherwise 0. PR 0 means "no tag".
- A valid result with dest_pr=0 (store, branch, rd=x0) still occupies a slot so the ROB gets its completion. Its tag reads 0.
- Squash: no grants that cycle; at the next edge all slots go invalid and rr_ptr <= 0. FUs discard their own pending results, since squash reaches them too.
- No starvation: any FU holding fu_finish is granted within ceil(NUM_FU/CDB_W)=3 cycles.

## Timing
- Reset (asynchronous, reset=0): cdb_packet_out all 0 (valid=0), cdb_t = {0,0,0}, rr_ptr=0, fu_grant=0.
- The first grant is possible in the cycle after reset deasserts.
- Grant latency: 0 cycles, combinational from fu_finish, rr_ptr and squash.
- Result latency: 1 cycle. A result granted in cycle N appears on cdb_packet_out/cdb_t in cycle N+1 and is held for exactly one cycle.
- Wrap-around: the scan passes index NUM_FU-1 back to 0 within the same cycle, e.g. ptr=6 grants 6, 7, 0.
- Squash together with requests: squash wins, and the requests stay pending until after the flush.
- Reset mid-operation: all state clears immediately; pending grants are lost.

## Configuration
- CDB_BRANCH_FIRST_EN defined: if fu_finish[BR_IDX]=1 and squash=0, BR_IDX always takes slot 0.
  - The remaining CDB_W-1 slots are filled by the round-robin scan, which skips BR_IDX.
  - The pointer update ignores BR_IDX unless BR_IDX was also the last round-robin winner.
- Not defined: BR_IDX is arbitrated like every other FU.

## Test plan
- Reset: assert reset=0 mid-run with fu_finish=8'hFF -> fu_grant=0, every cdb_packet_out.valid=0, cdb_t={0,0,0}, rr_ptr_display=0 immediately.
- Basic: ptr=0, fu_finish=8'b00000111 -> fu_grant=8'b00000111; next cycle slots 0/1/2 carry FU0/1/2 and rr_ptr=3.
- Fairness/wrap: fu_finish=8'hFF held, ungranted FUs keep requesting -> grants 8'b00000111, 8'b00111000, 8'b11000001 on successive cycles; rr_ptr 3, 6, 1.
- Single tag: only FU5 requests with dest_pr=17 -> fu_grant=8'b00100000; next cycle cdb_t.t0=17, t1=t2=0, slots 1/2 invalid.
- Squash: fu_finish=8'b00001111 with squash=1 -> fu_grant=0; next cycle all slots invalid and rr_ptr=0; after squash drops, the same request yields grants 8'b00000111.
- CDB_BRANCH_FIRST_EN: ptr=0, fu_finish=8'b10001111 -> fu_grant=8'b10000011, slot 0=FU7, slot 1=FU0, slot 2=FU1, rr_ptr=2.
